// File: rtl/admm_pkg.sv
// Shared types and helpers for the ADMM iteration scheduler: FSM state encoding,
// compute-stage identifiers and port-width helpers.
package admm_pkg;

  typedef enum logic [3:0] {
    IDLE,
    P_GO,
    P_WAIT,
    S_GO,
    S_WAIT,
    D_GO,
    D_WAIT,
    R_GO,
    R_WAIT,
    CHECK,
    DONE
  } admm_state_t;

  localparam logic [1:0] STG_PRIMAL = 2'd0;
  localparam logic [1:0] STG_SLACK  = 2'd1;
  localparam logic [1:0] STG_DUAL   = 2'd2;
  localparam logic [1:0] STG_RES    = 2'd3;

  // A single-knot horizon still needs a one-bit index.
  function automatic int knot_w(input int horizon);
    return (horizon > 1) ? $clog2(horizon) : 1;
  endfunction

  function automatic int iter_w(input int max_iter);
    return (max_iter > 0) ? $clog2(max_iter + 1) : 1;
  endfunction

endpackage

// File: rtl/admm_sequencer_if.sv
// Handshake bundle between the ADMM scheduler (master) and the compute units
// plus solve control (slave).
interface admm_sequencer_if
  import admm_pkg::*;
#(
  parameter int HORIZON  = 10,
  parameter int MAX_ITER = 100,
  parameter int W        = 16
);

  localparam int KW = knot_w(HORIZON);
  localparam int IW = iter_w(MAX_ITER);

  logic                solve_start;
  logic                abort;
  logic signed [W-1:0] tol_pri;
  logic signed [W-1:0] tol_dual;
  logic                primal_start;
  logic                primal_done;
  logic                slack_start;
  logic                slack_done;
  logic                dual_start;
  logic                dual_done;
  logic                res_start;
  logic                res_done;
  logic signed [W-1:0] pri_res;
  logic signed [W-1:0] dual_res;
  logic [KW-1:0]       knot_idx;
  logic                busy;
  logic                solve_done;
  logic                converged;
  logic [IW-1:0]       iter_count;

  modport master (
    input  solve_start, abort, tol_pri, tol_dual,
    input  primal_done, slack_done, dual_done, res_done, pri_res, dual_res,
    output primal_start, slack_start, dual_start, res_start,
    output knot_idx, busy, solve_done, converged, iter_count
  );

  modport slave (
    output solve_start, abort, tol_pri, tol_dual,
    output primal_done, slack_done, dual_done, res_done, pri_res, dual_res,
    input  primal_start, slack_start, dual_start, res_start,
    input  knot_idx, busy, solve_done, converged, iter_count
  );

endinterface

// File: rtl/admm_knot_counter.sv
// Knot index walker shared by the slack and dual phases; wraps to zero after
// the last knot so the next phase starts at knot 0 without an extra clear.
module admm_knot_counter
  import admm_pkg::*;
#(
  parameter int HORIZON = 10,
  parameter int KW      = knot_w(HORIZON)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [KW-1:0] count,
  output logic          last
);

  logic [KW-1:0] count_q;

  assign last  = (count_q == KW'(HORIZON - 1));
  assign count = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= last ? '0 : count_q + KW'(1);
    end
  end

endmodule

// File: rtl/admm_sequencer.sv
// ADMM iteration scheduler: pulses primal, per-knot slack, per-knot dual and
// residual units in turn, then checks residuals against tolerances.
module admm_sequencer
  import admm_pkg::*;
#(
  parameter int HORIZON  = 10,
  parameter int MAX_ITER = 100,
  parameter int W        = 16
) (
  input logic               clk,
  input logic               reset,
  admm_sequencer_if.master  bus
);

  localparam int KW = knot_w(HORIZON);
  localparam int IW = iter_w(MAX_ITER);

  admm_state_t         state_q, state_d;
  logic signed [W-1:0] pri_res_q, dual_res_q;
  logic [IW-1:0]       iter_q, iter_plus;
  logic                conv_q;
  logic [KW-1:0]       knot_q;
  logic                knot_clear, knot_inc, knot_last;
  logic                iter_clear, iter_inc, conv_set, res_load;
  logic                go;
  logic [1:0]          stage;
  logic                conv_now, iter_last;
  logic                abortable;

  admm_knot_counter #(.HORIZON(HORIZON), .KW(KW)) u_knot (
    .clk   (clk),
    .reset (reset),
    .clear (knot_clear),
    .inc   (knot_inc),
    .count (knot_q),
    .last  (knot_last)
  );

  assign iter_plus = iter_q + IW'(1);
  assign iter_last = (iter_plus == IW'(MAX_ITER));
  // Signed compare: negative residuals always satisfy a non-negative tolerance.
  assign conv_now  = (pri_res_q <= bus.tol_pri) && (dual_res_q <= bus.tol_dual);
  assign abortable = (state_q != IDLE) && (state_q != DONE);

  always_comb begin
    state_d    = state_q;
    knot_clear = 1'b0;
    knot_inc   = 1'b0;
    iter_clear = 1'b0;
    iter_inc   = 1'b0;
    conv_set   = 1'b0;
    res_load   = 1'b0;
    go         = 1'b0;
    stage      = STG_PRIMAL;
    unique case (state_q)
      IDLE: if (bus.solve_start) begin
        state_d    = P_GO;
        knot_clear = 1'b1;
        iter_clear = 1'b1;
      end
      P_GO: begin
        go      = 1'b1;
        stage   = STG_PRIMAL;
        state_d = P_WAIT;
      end
      P_WAIT: if (bus.primal_done) begin
        state_d    = S_GO;
        knot_clear = 1'b1;
      end
      S_GO: begin
        go      = 1'b1;
        stage   = STG_SLACK;
        state_d = S_WAIT;
      end
      S_WAIT: if (bus.slack_done) begin
        knot_inc = 1'b1;
        state_d  = knot_last ? D_GO : S_GO;
      end
      D_GO: begin
        go      = 1'b1;
        stage   = STG_DUAL;
        state_d = D_WAIT;
      end
      D_WAIT: if (bus.dual_done) begin
        knot_inc = 1'b1;
        state_d  = knot_last ? R_GO : D_GO;
      end
      R_GO: begin
        go      = 1'b1;
        stage   = STG_RES;
        state_d = R_WAIT;
      end
      R_WAIT: if (bus.res_done) begin
        res_load = 1'b1;
        state_d  = CHECK;
      end
      CHECK: begin
        iter_inc = 1'b1;
        if (conv_now) begin
          conv_set = 1'b1;
          state_d  = DONE;
        end else if (iter_last) begin
          state_d = DONE;
        end else begin
          state_d = P_GO;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides any handshake or check outcome in the same cycle.
    if (bus.abort && abortable) begin
      state_d  = DONE;
      knot_inc = 1'b0;
      iter_inc = 1'b0;
      conv_set = 1'b0;
      res_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      iter_q     <= '0;
      conv_q     <= 1'b0;
      pri_res_q  <= '0;
      dual_res_q <= '0;
    end else begin
      state_q <= state_d;
      if (iter_clear) begin
        iter_q <= '0;
        conv_q <= 1'b0;
      end else begin
        if (iter_inc) iter_q <= iter_plus;
        if (conv_set) conv_q <= 1'b1;
      end
      if (res_load) begin
        pri_res_q  <= bus.pri_res;
        dual_res_q <= bus.dual_res;
      end
    end
  end

  assign bus.primal_start = go && (stage == STG_PRIMAL);
  assign bus.slack_start  = go && (stage == STG_SLACK);
  assign bus.dual_start   = go && (stage == STG_DUAL);
  assign bus.res_start    = go && (stage == STG_RES);
  assign bus.knot_idx     = knot_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.solve_done   = (state_q == DONE);
  assign bus.converged    = conv_q;
  assign bus.iter_count   = iter_q;

endmodule

// File: tb/tb_admm_sequencer.sv
// Scoreboard bench for admm_sequencer: expected start-pulse sequences are queued
// per solve and compared against pulses observed from a behavioural unit model.
module tb_admm_sequencer;
  import admm_pkg::*;

  localparam int HORIZON  = 2;
  localparam int MAX_ITER = 3;
  localparam int W        = 16;
  localparam int IW       = iter_w(MAX_ITER);

  logic clk;
  logic reset;

  admm_sequencer_if #(.HORIZON(HORIZON), .MAX_ITER(MAX_ITER), .W(W)) bus ();

  admm_sequencer #(.HORIZON(HORIZON), .MAX_ITER(MAX_ITER), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  int exp_q[$];
  int obs_q[$];

  bit hold_start;
  bit spurious_dual;
  int stall_extra;
  int abort_iter;
  int wait_bad;
  int busy_low;
  int multi_start;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int code(input logic [1:0] stg, input int knot);
    return int'(stg) * 16 + knot;
  endfunction

  function automatic void push_iter();
    exp_q.push_back(code(STG_PRIMAL, 0));
    for (int k = 0; k < HORIZON; k++) exp_q.push_back(code(STG_SLACK, k));
    for (int k = 0; k < HORIZON; k++) exp_q.push_back(code(STG_DUAL, k));
    exp_q.push_back(code(STG_RES, 0));
  endfunction

  // Behavioural compute units: each done returns after 1 + extra WAIT cycles.
  // Cycle 1 is the cycle P_GO occupies; done_cycle is the cycle DONE occupies.
  task automatic run_solve(input int max_cycles, input int reset_at, output int done_cycle);
    int c, p_cnt, s_cnt, d_cnt, r_cnt, s_knot, d_knot, prim_seen, nstart;
    bit spur;
    obs_q.delete();
    wait_bad = 0; busy_low = 0; multi_start = 0; done_cycle = -1;
    p_cnt = 0; s_cnt = 0; d_cnt = 0; r_cnt = 0; s_knot = 0; d_knot = 0;
    prim_seen = 0; spur = 1'b0; c = 0;
    @(negedge clk);
    bus.solve_start = 1'b1;
    while (done_cycle < 0 && c < max_cycles) begin
      @(negedge clk);
      c++;
      if (!hold_start) bus.solve_start = 1'b0;
      bus.primal_done = 1'b0; bus.slack_done = 1'b0;
      bus.dual_done   = 1'b0; bus.res_done   = 1'b0;
      bus.abort       = 1'b0;
      if (reset_at == c) begin
        reset = 1'b1;
        break;
      end
      if (bus.solve_done) begin
        done_cycle = c;
        bus.solve_start = 1'b0;
      end
      if (!bus.busy) busy_low++;
      nstart = int'(bus.primal_start) + int'(bus.slack_start) + int'(bus.dual_start) + int'(bus.res_start);
      if (nstart > 1) multi_start++;
      if ((p_cnt + s_cnt + d_cnt + r_cnt) > 0 && nstart != 0) wait_bad++;
      if (s_cnt > 0 && int'(bus.knot_idx) != s_knot) wait_bad++;
      if (d_cnt > 0 && int'(bus.knot_idx) != d_knot) wait_bad++;
      if (p_cnt > 0) begin p_cnt--; if (p_cnt == 0) bus.primal_done = 1'b1; end
      if (s_cnt > 0) begin
        s_cnt--;
        if (s_cnt == 0) begin
          bus.slack_done = 1'b1;
          if (abort_iter > 0 && prim_seen == abort_iter && s_knot == 0) bus.abort = 1'b1;
        end
      end
      if (d_cnt > 0) begin d_cnt--; if (d_cnt == 0) bus.dual_done = 1'b1; end
      if (r_cnt > 0) begin r_cnt--; if (r_cnt == 0) bus.res_done = 1'b1; end
      if (spur) begin bus.dual_done = 1'b1; spur = 1'b0; end
      if (bus.primal_start) begin
        obs_q.push_back(code(STG_PRIMAL, 0)); p_cnt = 1; prim_seen++;
      end
      if (bus.slack_start) begin
        s_knot = int'(bus.knot_idx); obs_q.push_back(code(STG_SLACK, s_knot)); s_cnt = 1;
        if (spurious_dual) spur = 1'b1;
      end
      if (bus.dual_start) begin
        d_knot = int'(bus.knot_idx); obs_q.push_back(code(STG_DUAL, d_knot));
        d_cnt = 1 + ((d_knot == 1 && prim_seen == 1) ? stall_extra : 0);
      end
      if (bus.res_start) begin
        obs_q.push_back(code(STG_RES, 0)); r_cnt = 1;
      end
    end
  endtask

  task automatic set_res(input int pr, input int dr, input int tp, input int td);
    bus.pri_res  = W'(pr);
    bus.dual_res = W'(dr);
    bus.tol_pri  = W'(tp);
    bus.tol_dual = W'(td);
  endtask

  task automatic test_reset();
    bus.solve_start = 0; bus.abort = 0;
    bus.primal_done = 0; bus.slack_done = 0; bus.dual_done = 0; bus.res_done = 0;
    set_res(0, 0, 0, 0);
    hold_start = 0; spurious_dual = 0; stall_extra = 0; abort_iter = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.solve_done !== 1'b0 || bus.converged !== 1'b0) $display("[TB] FAIL reset_flags busy/done/conv=%b%b%b expected 000", bus.busy, bus.solve_done, bus.converged);
    else passed++;
    checks++;
    if (bus.iter_count !== IW'(0)) $display("[TB] FAIL reset_iter got %0d expected 0", bus.iter_count);
    else passed++;
    checks++;
    if (bus.knot_idx !== '0) $display("[TB] FAIL reset_knot got %0d expected 0", bus.knot_idx);
    else passed++;
    checks++;
    if ({bus.primal_start, bus.slack_start, bus.dual_start, bus.res_start} !== 4'b0) $display("[TB] FAIL reset_starts got %b expected 0000", {bus.primal_start, bus.slack_start, bus.dual_start, bus.res_start});
    else passed++;
  endtask

  task automatic test_converge_one();
    int dc, o;
    set_res(3, 2, 5, 5);
    push_iter();
    run_solve(60, 0, dc);
    checks++;
    if (dc !== 14) $display("[TB] FAIL conv1_latency got %0d expected 14", dc);
    else passed++;
    checks++;
    if (bus.converged !== 1'b1 || bus.iter_count !== IW'(1)) $display("[TB] FAIL conv1_result conv=%b iter=%0d expected conv=1 iter=1", bus.converged, bus.iter_count);
    else passed++;
    while (exp_q.size() > 0) begin
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      checks++;
      if (o !== exp_q[0]) $display("[TB] FAIL conv1_pulse got %0d expected %0d", o, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
    end
    checks++;
    if (obs_q.size() != 0 || wait_bad != 0 || multi_start != 0 || busy_low != 0) $display("[TB] FAIL conv1_protocol extra=%0d wait_bad=%0d multi=%0d busy_low=%0d expected all 0", obs_q.size(), wait_bad, multi_start, busy_low);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.converged !== 1'b1 || bus.iter_count !== IW'(1)) $display("[TB] FAIL conv1_idle busy=%b conv=%b iter=%0d expected 0/1/1", bus.busy, bus.converged, bus.iter_count);
    else passed++;
  endtask

  task automatic test_never_converge();
    int dc, o;
    set_res(9, 0, 5, 5);
    for (int i = 0; i < MAX_ITER; i++) push_iter();
    run_solve(80, 0, dc);
    checks++;
    if (dc !== 40) $display("[TB] FAIL maxiter_latency got %0d expected 40", dc);
    else passed++;
    checks++;
    if (bus.converged !== 1'b0 || bus.iter_count !== IW'(3)) $display("[TB] FAIL maxiter_result conv=%b iter=%0d expected conv=0 iter=3", bus.converged, bus.iter_count);
    else passed++;
    while (exp_q.size() > 0) begin
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      checks++;
      if (o !== exp_q[0]) $display("[TB] FAIL maxiter_pulse got %0d expected %0d", o, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
    end
    checks++;
    if (obs_q.size() != 0 || wait_bad != 0 || multi_start != 0) $display("[TB] FAIL maxiter_protocol extra=%0d wait_bad=%0d multi=%0d expected 0", obs_q.size(), wait_bad, multi_start);
    else passed++;
  endtask

  task automatic test_stall();
    int dc, o;
    set_res(3, 2, 5, 5);
    stall_extra = 6;
    push_iter();
    run_solve(60, 0, dc);
    stall_extra = 0;
    checks++;
    if (dc !== 20) $display("[TB] FAIL stall_latency got %0d expected 20", dc);
    else passed++;
    checks++;
    if (wait_bad != 0 || busy_low != 0) $display("[TB] FAIL stall_wait wait_bad=%0d busy_low=%0d expected 0", wait_bad, busy_low);
    else passed++;
    while (exp_q.size() > 0) begin
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      checks++;
      if (o !== exp_q[0]) $display("[TB] FAIL stall_pulse got %0d expected %0d", o, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
    end
    checks++;
    if (obs_q.size() != 0 || bus.converged !== 1'b1) $display("[TB] FAIL stall_result extra=%0d conv=%b expected 0/1", obs_q.size(), bus.converged);
    else passed++;
  endtask

  task automatic test_abort();
    int dc, o;
    set_res(9, 0, 5, 5);
    abort_iter = 2;
    push_iter();
    exp_q.push_back(code(STG_PRIMAL, 0));
    exp_q.push_back(code(STG_SLACK, 0));
    run_solve(60, 0, dc);
    abort_iter = 0;
    checks++;
    if (dc !== 18) $display("[TB] FAIL abort_latency got %0d expected 18", dc);
    else passed++;
    checks++;
    if (bus.converged !== 1'b0 || bus.iter_count !== IW'(1)) $display("[TB] FAIL abort_result conv=%b iter=%0d expected conv=0 iter=1", bus.converged, bus.iter_count);
    else passed++;
    while (exp_q.size() > 0) begin
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      checks++;
      if (o !== exp_q[0]) $display("[TB] FAIL abort_pulse got %0d expected %0d", o, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
    end
    checks++;
    if (obs_q.size() != 0) $display("[TB] FAIL abort_extra_pulses got %0d expected 0", obs_q.size());
    else passed++;
  endtask

  task automatic test_ignored_inputs();
    int dc, o;
    set_res(-4, -4, 0, 0);
    hold_start = 1;
    spurious_dual = 1;
    push_iter();
    run_solve(60, 0, dc);
    hold_start = 0;
    spurious_dual = 0;
    checks++;
    if (dc !== 14) $display("[TB] FAIL ignored_latency got %0d expected 14", dc);
    else passed++;
    checks++;
    if (bus.converged !== 1'b1 || bus.iter_count !== IW'(1)) $display("[TB] FAIL negres_result conv=%b iter=%0d expected conv=1 iter=1", bus.converged, bus.iter_count);
    else passed++;
    while (exp_q.size() > 0) begin
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      checks++;
      if (o !== exp_q[0]) $display("[TB] FAIL ignored_pulse got %0d expected %0d", o, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || bus.busy !== 1'b0 || bus.primal_start !== 1'b0) $display("[TB] FAIL ignored_restart extra=%0d busy=%b primal=%b expected 0/0/0", obs_q.size(), bus.busy, bus.primal_start);
    else passed++;
  endtask

  task automatic test_reset_mid_solve();
    int dc, o, seen;
    set_res(3, 2, 5, 5);
    run_solve(60, 8, dc);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.solve_done !== 1'b0 || bus.converged !== 1'b0 || bus.iter_count !== IW'(0) || bus.knot_idx !== '0) $display("[TB] FAIL midreset_outputs busy=%b done=%b conv=%b iter=%0d knot=%0d expected all 0", bus.busy, bus.solve_done, bus.converged, bus.iter_count, bus.knot_idx);
    else passed++;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.primal_start || bus.slack_start || bus.dual_start || bus.res_start || bus.busy) seen++;
    end
    checks++;
    if (seen != 0) $display("[TB] FAIL midreset_quiet got %0d active cycles expected 0", seen);
    else passed++;
    push_iter();
    run_solve(60, 0, dc);
    checks++;
    if (dc !== 14 || bus.converged !== 1'b1 || bus.iter_count !== IW'(1)) $display("[TB] FAIL midreset_rerun latency=%0d conv=%b iter=%0d expected 14/1/1", dc, bus.converged, bus.iter_count);
    else passed++;
    while (exp_q.size() > 0) begin
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      checks++;
      if (o !== exp_q[0]) $display("[TB] FAIL midreset_pulse got %0d expected %0d", o, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_converge_one();
    test_never_converge();
    test_stall();
    test_abort();
    test_ignored_inputs();
    test_reset_mid_solve();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/admm_sequencer.md
# admm_sequencer

Top-level ADMM iteration scheduler for the MPC solver. On `solve_start` it repeatedly sequences the primal solve, the per-knot slack projection, the per-knot `dual_update` (y/g update), and the residual unit. It then checks the residuals against tolerances and stops on convergence, `MAX_ITER`, or `abort`. Each compute unit keeps its own datapath; this block only issues start pulses, drives the knot index and counts iterations.

## Interface
- `HORIZON`, 10, knots per trajectory (≥1)
- `MAX_ITER`, 100, iteration cap (≥1)
- `W`, 16, residual/tolerance width (signed)
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `solve_start`  in  1  begin a solve; honoured only in IDLE
- `abort`  in  1  terminate the current solve
- `tol_pri`, `tol_dual`  in  W  signed tolerances, sampled every CHECK
- `primal_start`  out  1  one-cycle pulse to the primal (backward/forward pass) unit
- `primal_done`  in  1  primal completion
- `slack_start`  out  1  one-cycle pulse to the slack unit, for knot `knot_idx`
- `slack_done`  in  1  slack completion
- `dual_start`  out  1  one-cycle pulse to `dual_update`, for knot `knot_idx`
- `dual_done`  in  1  `dual_update` completion
- `res_start`  out  1  one-cycle pulse to the residual unit
- `res_done`  in  1  residuals valid
- `pri_res`, `dual_res`  in  W  signed residuals, captured when `res_done` is accepted
- `knot_idx`  out  $clog2(HORIZON) (min 1)  current knot
- `busy`  out  1  high in every state except IDLE
- `solve_done`  out  1  one-cycle pulse at the end of a solve
- `converged`  out  1  result flag, held until the next accepted `solve_start`
- `iter_count`  out  $clog2(MAX_ITER+1)  completed iterations, held until the next accepted `solve_start`

## Operation
- States:
  - IDLE
  - P_GO, P_WAIT
  - S_GO, S_WAIT
  - D_GO, D_WAIT
  - R_GO, R_WAIT
  - CHECK
  - DONE
- IDLE, `solve_start`=1: clear `iter_count`, `converged` and `knot_idx`; go to P_GO.
- Each X_GO state asserts its `*_start` for exactly one cycle, then moves to X_WAIT.
- X_WAIT holds until the matching `*_done`=1.
  - `*_done` is sampled only in X_WAIT. Done asserted during X_GO or any other state is ignored.
- P_WAIT done: go to S_GO with `knot_idx`=0.
- S_WAIT done:
  - `knot_idx`<HORIZON-1: increment `knot_idx`, go to S_GO.
  - otherwise: `knot_idx`=0, go to D_GO.
- D_WAIT: same knot walk as S_WAIT. After the last knot, `knot_idx`=0 and go to R_GO.
- R_WAIT done: latch `pri_res` and `dual_res`; go to CHECK.
- CHECK:
  - `iter_count` += 1.
  - `conv` = (pri_res_q ≤ tol_pri) && (dual_res_q ≤ tol_dual), signed compare. Negative residuals count as converged.
  - `conv`: set `converged`=1 and go to DONE.
  - else if the new `iter_count`==MAX_ITER: go to DONE with `converged`=0.
  - else: go to P_GO.
- DONE: `solve_done`=1 for one cycle, then IDLE.
- `abort`=1 in any state other than IDLE or DONE: next state is DONE, `converged`=0, `iter_count` unchanged.
  - `abort` beats a simultaneous `*_done` and a simultaneous CHECK result.
- `solve_start` outside IDLE is ignored and is not queued. `solve_start` during DONE is also ignored.
- The `*_start` outputs are mutually exclusive; at most one is high in any cycle.

## Timing
- Reset (synchronous): state=IDLE.
  - All `*_start`, `busy`, `solve_done`, `converged` = 0.
  - `iter_count`=0, `knot_idx`=0, latched residuals = 0.
- Reset mid-solve: outputs return to those values on the next edge, and no further start pulses are issued.
- `solve_start` is sampled at edge e0. P_GO (`primal_start` high) occupies the cycle after e0.
- With every `*_done` returning in the first WAIT cycle:
  - One iteration takes 5 + 4·HORIZON cycles: P 2, S 2H, D 2H, R 2, CHECK 1.
  - `solve_done` goes high `iters`·(5+4·HORIZON)+1 cycles after e0.
- `knot_idx` is stable throughout each S_GO/S_WAIT and D_GO/D_WAIT pair.
- `busy` rises with P_GO and falls on the cycle after DONE.

## Structure
- `admm_pkg`: state enum `admm_state_t`, stage-index constants (STG_PRIMAL, STG_SLACK, STG_DUAL, STG_RES), and the width helper functions.
- Sub-module `admm_knot_counter`: wrap counter 0..HORIZON-1 with `clear`, `inc` and `last` outputs. It is shared by the S and D phases.
- The top level contains the FSM, the iteration counter, the residual latches and the comparators.

## Test plan
All scenarios use HORIZON=2, MAX_ITER=3, and every done one cycle after its start.
- Converge in one iteration: `pri_res`=3, `dual_res`=2, `tol`=5/5.
  - Pulse order: P, S(k0), S(k1), D(k0), D(k1), R.
  - `solve_done` 14 cycles after e0; `converged`=1, `iter_count`=1.
- Never converge: `pri_res`=9, `tol_pri`=5.
  - `solve_done` after 3·13+1=40 cycles; `converged`=0, `iter_count`=3.
- Stalled done: hold `dual_done` low for 7 cycles on k1.
  - FSM stays in D_WAIT with `knot_idx`=1; no other start pulse is issued; total latency grows by 6.
- Abort: raise `abort` during S_WAIT of iteration 2, in the same cycle as `slack_done`.
  - Next cycle is DONE, `solve_done` pulses, `converged`=0, `iter_count`=1, no D pulse.
- Ignored inputs:
  - `solve_start` held high during a solve restarts nothing.
  - Spurious `dual_done` in S_WAIT is ignored.
  - Negative residual −4 with `tol`=0 counts as converged.
- Reset at cycle 8 of a solve: all outputs take their reset values on the next edge; a following `solve_start` runs cleanly from `iter_count`=0.
